// File: rtl/requan_sched_pkg.sv
// Shared requantize-stage types, default geometry and the common 16-bit
// saturation helper used by every requantize datapath.
`ifndef HWORD
`define HWORD 16
`endif

package requan_sched_pkg;

    localparam int NUM_CH_DEF = 64;
    localparam int CH_W_DEF   = 6;
    localparam int PIX_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rq_state_e;

    // Clamp a 17-bit signed difference into the signed 16-bit range.
    function automatic logic [15:0] sat16(input logic signed [16:0] diff);
        if (diff <= -17'sd32768)
            return 16'h8000;
        else if (diff >= 17'sd32767)
            return 16'h7fff;
        else
            return diff[15:0];
    endfunction

endpackage

// File: rtl/requan1.sv
// Requan1 stage: purely combinational subtract-and-saturate, or a straight
// pass-through when requantization is disabled.
`ifndef HWORD
`define HWORD 16
`endif

module requan1
    import requan_sched_pkg::*;
(
    input  logic [`HWORD-1:0] in_data,
    input  logic [`HWORD-1:0] bias,
    input  logic              do_requan,
    output logic [`HWORD-1:0] out_data
);

    logic signed [16:0] diff;

    assign diff     = $signed({in_data[15], in_data}) - $signed({bias[15], bias});
    assign out_data = do_requan ? sat16(diff) : in_data;

endmodule

// File: rtl/requan_bias_buf.sv
// Per-output-channel bias register file: synchronous write, asynchronous
// read, cleared by reset.
module requan_bias_buf #(
    parameter int NUM_CH = 64,
    parameter int CH_W   = 6,
    parameter int W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [CH_W-1:0] waddr,
    input  logic [W-1:0]    wdata,
    input  logic [CH_W-1:0] raddr,
    output logic [W-1:0]    rdata
);

    logic [NUM_CH-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we)
            mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mem_q <= '0;
        else
            mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/requan_sched.sv
// Requantize sequencer: walks a channel-innermost tile, applies the
// per-channel bias through Requan1 and drives a single output register.
`ifndef HWORD
`define HWORD 16
`endif

module requan_sched
    import requan_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = CH_W_DEF,
    parameter int PIX_W  = PIX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CH_W:0]     cfg_num_ch,
    input  logic [PIX_W-1:0]  cfg_num_pix,
    input  logic              cfg_do_requan,
    input  logic              bias_we,
    input  logic [CH_W-1:0]   bias_addr,
    input  logic [`HWORD-1:0] bias_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [`HWORD-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [`HWORD-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [CH_W:0]    NCH_ONE = 1;
    localparam logic [CH_W-1:0]  CH_ONE  = 1;
    localparam logic [PIX_W-1:0] PIX_ONE = 1;

    rq_state_e          state_q, state_d;
    logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CH_W:0]      num_ch_q, num_ch_d;
    logic [PIX_W-1:0]   num_pix_q, num_pix_d;
    logic               do_requan_q, do_requan_d;
    logic               out_valid_q, out_valid_d;
    logic [`HWORD-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    logic [`HWORD-1:0]  bias_rd;
    logic [`HWORD-1:0]  rq_data;
    logic               bias_wen;
    logic               accept;
    logic               last_ch;
    logic               last_pix;

    // Bias updates are only safe while no tile is consuming the buffer.
    assign bias_wen = bias_we && (state_q == IDLE || state_q == DONE);

    requan_bias_buf #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .W      (`HWORD)
    ) u_bias_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bias_wen),
        .waddr  (bias_addr),
        .wdata  (bias_wdata),
        .raddr  (ch_cnt_q),
        .rdata  (bias_rd)
    );

    requan1 u_requan1 (
        .in_data   (in_data),
        .bias      (bias_rd),
        .do_requan (do_requan_q),
        .out_data  (rq_data)
    );

    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_ch  = ({1'b0, ch_cnt_q} == (num_ch_q - NCH_ONE));
    assign last_pix = (pix_cnt_q == (num_pix_q - PIX_ONE));

    always_comb begin
        state_d     = state_q;
        ch_cnt_d    = ch_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        num_ch_d    = num_ch_q;
        num_pix_d   = num_pix_q;
        do_requan_d = do_requan_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_ch_d    = cfg_num_ch;
                    num_pix_d   = cfg_num_pix;
                    do_requan_d = cfg_do_requan;
                    ch_cnt_d    = '0;
                    pix_cnt_d   = '0;
                    if (cfg_num_ch == '0 || cfg_num_pix == '0)
                        state_d = DONE;
                    else
                        state_d = RUN;
                end
            end
            RUN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
                // A new accept overrides the drain of the previous element.
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rq_data;
                    out_last_d  = last_ch && last_pix;
                    if (last_ch) begin
                        ch_cnt_d  = '0;
                        pix_cnt_d = pix_cnt_q + PIX_ONE;
                    end else begin
                        ch_cnt_d  = ch_cnt_q + CH_ONE;
                    end
                    if (last_ch && last_pix)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                ch_cnt_d  = '0;
                pix_cnt_d = '0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            num_ch_q    <= '0;
            num_pix_q   <= '0;
            do_requan_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_cnt_q    <= ch_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            num_ch_q    <= num_ch_d;
            num_pix_q   <= num_pix_d;
            do_requan_q <= do_requan_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_requan_sched.sv
// Directed bench for requan_sched: scoreboard of expected outputs pushed at
// input accept, popped and compared at each output handshake.
module tb_requan_sched;

    typedef struct {
        logic [15:0] d;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  cfg_num_ch;
    logic [15:0] cfg_num_pix;
    logic        cfg_do_requan;
    logic        bias_we;
    logic [5:0]  bias_addr;
    logic [15:0] bias_wdata;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_hs_cyc = -10;
    int          done_cnt = 0;
    logic        bp_en    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    logic [15:0] bias_m [64];
    logic [15:0] din [$];
    exp_t        sb  [$];

    requan_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_num_ch    (cfg_num_ch),
        .cfg_num_pix   (cfg_num_pix),
        .cfg_do_requan (cfg_do_requan),
        .bias_we       (bias_we),
        .bias_addr     (bias_addr),
        .bias_wdata    (bias_wdata),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_f(input logic [15:0] d, input logic [15:0] b, input logic rq);
        int diff;
        if (!rq) return d;
        diff = int'($signed(d)) - int'($signed(b));
        if (diff > 32767) diff = 32767;
        else if (diff < -32768) diff = -32768;
        return diff[15:0];
    endfunction

    // Output monitor: scoreboard pop, hold-stability and backpressure rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid && !out_ready)
                chk("bp_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("FAIL sb_underflow observed=unexpected_output expected=none data=%0d", out_data);
                end
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.last);
                    if (out_last) last_hs_cyc = cyc;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) done_cnt++;
        end
    end

    task automatic wbias(input logic [5:0] a, input logic [15:0] v, input logic upd);
        bias_we = 1'b1; bias_addr = a; bias_wdata = v;
        @(posedge clk); #1;
        bias_we = 1'b0;
        if (upd) bias_m[a] = v;
    endtask

    task automatic start_tile(input logic [6:0] nch, input logic [15:0] npix, input logic rq);
        chk("cfg_legal", {31'd0, nch <= 7'd64}, 1);
        cfg_num_ch = nch; cfg_num_pix = npix; cfg_do_requan = rq; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] e, input logic l);
        int n;
        exp_t x;
        in_valid = 1'b1; in_data = d; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 1000);
        chk("accept_timeout", in_ready, 1);
        x.d = e; x.last = l;
        sb.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 1000);
        chk("done_seen", done, 1);
        chk("done_latency", cyc - last_hs_cyc, 1);
        chk("sb_drained", sb.size(), 0);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_tile(input logic [6:0] nch, input logic [15:0] npix, input logic rq);
        logic [15:0] d;
        start_tile(nch, npix, rq);
        for (int p = 0; p < int'(npix); p++) begin
            for (int c = 0; c < int'(nch); c++) begin
                d = din.pop_front();
                send(d, ref_f(d, bias_m[c], rq), (c == int'(nch) - 1) && (p == int'(npix) - 1));
            end
        end
        in_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int dc;
        for (int i = 0; i < 64; i++) bias_m[i] = '0;
        rst_n = 1'b0; start = 1'b0; cfg_num_ch = '0; cfg_num_pix = '0;
        cfg_do_requan = 1'b0; bias_we = 1'b0; bias_addr = '0; bias_wdata = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic tile: expected 10,25,20,-80 twice, last on element 8.
        wbias(0, 16'd10, 1); wbias(1, 16'hFFFB, 1); wbias(2, 16'd0, 1); wbias(3, 16'd100, 1);
        repeat (8) din.push_back(16'd20);
        run_tile(7'd4, 16'd2, 1'b1);

        // Saturation at both rails and near the top rail.
        wbias(0, 16'hFFFF, 1); wbias(1, 16'd1, 1); wbias(2, 16'hFF9C, 1);
        din.push_back(16'h7FFF); din.push_back(16'h8000); din.push_back(16'd32700);
        run_tile(7'd3, 16'd1, 1'b1);

        // Pass-through ignores the bias.
        wbias(0, 16'd500, 1);
        din.push_back(16'hFFF9);
        run_tile(7'd1, 16'd1, 1'b0);

        // Single channel: bias[0] on every element.
        din.push_back(16'd1000); din.push_back(16'd0); din.push_back(16'hFFFF); din.push_back(16'd600);
        run_tile(7'd1, 16'd4, 1'b1);

        // Backpressure with random stalls.
        wbias(0, 16'd7, 1); wbias(1, 16'hFF00, 1); wbias(2, 16'd300, 1);
        for (int i = 0; i < 15; i++) din.push_back(16'($urandom));
        bp_en = 1'b1;
        run_tile(7'd3, 16'd5, 1'b1);
        bp_en = 1'b0;
        @(posedge clk); #1;

        // Empty tile: straight to DONE, no input accepted.
        cfg_num_ch = 7'd4; cfg_num_pix = 16'd0; cfg_do_requan = 1'b1;
        start = 1'b1; in_valid = 1'b1; in_data = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("np0_busy", busy, 1);
        chk("np0_done", done, 1);
        chk("np0_in_ready", in_ready, 0);
        @(negedge clk);
        chk("np0_busy_end", busy, 0);
        chk("np0_done_end", done, 0);
        chk("np0_in_ready_end", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset mid-tile after three accepted elements.
        wbias(0, 16'd10, 1); wbias(1, 16'hFFFB, 1); wbias(2, 16'd0, 1); wbias(3, 16'd100, 1);
        start_tile(7'd4, 16'd2, 1'b1);
        for (int c = 0; c < 3; c++) send(16'd20, ref_f(16'd20, bias_m[c], 1'b1), 1'b0);
        dc = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_last", out_last, 0);
        sb.delete();
        for (int i = 0; i < 64; i++) bias_m[i] = '0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt, dc);
        chk("mid_rst_idle", busy, 0);

        // Bias buffer cleared by reset: output equals input.
        repeat (4) din.push_back(16'd20);
        run_tile(7'd4, 16'd1, 1'b1);

        // Write during RUN must be dropped.
        start_tile(7'd1, 16'd2, 1'b1);
        wbias(0, 16'd777, 0);
        send(16'd5, ref_f(16'd5, bias_m[0], 1'b1), 1'b0);
        send(16'd6, ref_f(16'd6, bias_m[0], 1'b1), 1'b1);
        in_valid = 1'b0;
        wait_done();
        d = 16'd0;
        din.push_back(d);
        run_tile(7'd1, 16'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
